mux_tree_pipe: RTL and testbench
================================

// Module: mux_tree_pipe
// PURPOSE
//   Parametrised, pipelined N:1 multiplexer tree built from radix-4 select stages,
//   one register rank per stage. Multi-bit data words, valid/ready flow control and
//   bubble collapsing. Generalises the single-bit 16:1 tree for ALU operand/result steering.
// PARAMETERS
//   WIDTH     8   data word width in bits (>=1)
//   SEL_BITS  4   select width; N = 2**SEL_BITS inputs (1..8)
//   Derived: STAGES = ceil(SEL_BITS/2); last stage is 2:1 when SEL_BITS is odd
// PORTS
//   clk        in   1               rising-edge clock
//   rst        in   1               asynchronous, active-high reset
//   in_valid   in   1               a_in/sel are valid this cycle
//   in_ready   out  1               stage 0 can accept; transfer = in_valid & in_ready
//   a_in       in   N*WIDTH         input words; word i = a_in[i*WIDTH +: WIDTH]
//   sel        in   SEL_BITS        binary index of the word to forward
//   out_valid  out  1               out/out_sel hold a result
//   out_ready  in   1               sink accepts; transfer = out_valid & out_ready
//   out        out  WIDTH           selected word (registered)
//   out_sel    out  SEL_BITS        sel value that produced out (registered, for tagging)
// BEHAVIOUR
// - Reset (async assert, sync release): all stage valid bits 0, all data/sel regs 0;
//   out=0, out_sel=0, out_valid=0. in_ready is 1 from the first cycle after release.
// - Stage k (0..STAGES-1): consumes sel[2k+1:2k] (sel[2k] only in the odd last stage),
//   picks 1 of 4 (or 2) words per group, registers the reduced word vector, the full
//   original sel, and valid bit v[k]. Stage 0 input is a_in; output of last stage is out.
// - Word order: within each group, index 0 is the lowest-order word, as in a_in.
// - Latency: exactly STAGES cycles from accepted input to out_valid with no stalls
//   (default 2). Throughput: 1 word/cycle while out_ready stays 1.
// - Per-stage advance: ld[k] = ~v[k] | ld[k+1]; ld[STAGES] = out_ready.
//   in_ready = ld[0] (combinational from out_ready; no registered skid).
//   On ld[k]: v[k] <= v[k-1] (v[-1] = in_valid), data/sel regs load; else all hold.
// - Bubble collapse: an empty stage loads even while downstream is stalled, so
//   STAGES words are buffered under sustained out_ready=0; then in_ready=0.
// - Stall: while out_valid & ~out_ready, out and out_sel are stable (no change).
// - Data regs load only when the upstream valid is 1 (power saving); when an empty
//   slot propagates, data regs hold their previous value and v[k] clears.
// - Out-of-range sel impossible (N = 2**SEL_BITS); a sel change while in_valid=0 has no effect.
// - in_valid with in_ready=0: nothing captured; the source must hold a_in/sel.
// - Reset mid-operation: every in-flight word is discarded, out_valid drops in the
//   same cycle as rst assertion; no partial word is ever presented.
// - SEL_BITS=1: single 2:1 stage, latency 1.
// TESTING (WIDTH=8, SEL_BITS=4, a_in word i = 8'hA0+i unless stated)
// 1. Reset: rst=1 mid-stream with 2 words in flight -> out_valid=0, out=0 immediately;
//    after release in_ready=1, no stale word emerges.
// 2. Sweep sel=0..15 back-to-back, out_ready=1 -> out = A0..AF, out_sel = 0..15,
//    each exactly 2 cycles after its accept, out_valid held 1 for 16 cycles.
// 3. Backpressure: 3 words sel=3,7,12 while out_ready=0 -> 2 accepted, in_ready=0,
//    out=A3 stable; raise out_ready -> A3, A7, then AC delivered in order, none lost.
// 4. Bubbles: in_valid pattern 1,0,1,0 with sel=5,9 -> out_valid pattern 0,0,1,0,1,
//    out = A5 then A9; data regs not updated on bubble cycles.
// 5. Data width: a_in word 15 = 8'hFF, others 8'h00, sel=15 -> out=8'hFF;
//    sel=14 -> out=8'h00 (catches group/word misindexing).
// 6. Odd select (SEL_BITS=3, N=8): sel=6 -> out = word 6 after 2 cycles; SEL_BITS=1,
//    sel=1 -> out = word 1 after 1 cycle.

Source files
------------

// File: rtl/mux_tree_pipe_if.sv
// rtl/mux_tree_pipe_if.sv - stream bundle for the pipelined mux tree (input words/select in, selected word out)
interface mux_tree_pipe_if #(
    parameter int WIDTH    = 8,
    parameter int SEL_BITS = 4
);
    localparam int N = 2 ** SEL_BITS;

    logic                  in_valid;
    logic                  in_ready;
    logic [N*WIDTH-1:0]    a_in;
    logic [SEL_BITS-1:0]   sel;
    logic                  out_valid;
    logic                  out_ready;
    logic [WIDTH-1:0]      out;
    logic [SEL_BITS-1:0]   out_sel;

    modport master (
        output in_valid, a_in, sel, out_ready,
        input  in_ready, out_valid, out, out_sel
    );

    modport slave (
        input  in_valid, a_in, sel, out_ready,
        output in_ready, out_valid, out, out_sel
    );
endinterface

// File: rtl/mux_tree_pipe.sv
// rtl/mux_tree_pipe.sv - pipelined N:1 radix-4 mux tree with valid/ready and bubble collapsing
module mux_tree_pipe #(
    parameter int WIDTH    = 8,
    parameter int SEL_BITS = 4
) (
    input  logic              clk,
    input  logic              rst,
    mux_tree_pipe_if.slave    bus
);
    localparam int STAGES = (SEL_BITS + 1) / 2;

    logic [STAGES-1:0] v;
    logic [STAGES-1:0] ld;

    for (genvar k = 0; k < STAGES; k++) begin : stg
        localparam int IN_W  = 2 ** (SEL_BITS - 2 * k);
        localparam int RADIX = ((SEL_BITS - 2 * k) >= 2) ? 4 : 2;
        localparam int OUT_W = IN_W / RADIX;
        localparam int SB    = (RADIX == 4) ? 2 : 1;

        logic [IN_W*WIDTH-1:0]  d_in;
        logic [SEL_BITS-1:0]    s_in;
        logic                   v_in;
        logic [SB-1:0]          idx;
        logic [OUT_W*WIDTH-1:0] d_nxt;
        logic [OUT_W*WIDTH-1:0] d_q;
        logic [SEL_BITS-1:0]    s_q;
        logic                   v_q;

        if (k == 0) begin : g_src
            assign d_in = bus.a_in;
            assign s_in = bus.sel;
            assign v_in = bus.in_valid;
        end else begin : g_chain
            assign d_in = stg[k-1].d_q;
            assign s_in = stg[k-1].s_q;
            assign v_in = stg[k-1].v_q;
        end

        assign idx = s_in[2*k +: SB];

        always_comb begin
            d_nxt = '0;
            for (int g = 0; g < OUT_W; g++) begin
                d_nxt[g*WIDTH +: WIDTH] = d_in[(g*RADIX + int'(idx))*WIDTH +: WIDTH];
            end
        end

        // A stage advances if it is empty or anything downstream can move.
        assign ld[k] = bus.out_ready | ~(&v[STAGES-1:k]);
        assign v[k]  = v_q;

        // Data/sel only capture real words; bubbles just clear the valid bit.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_q <= 1'b0;
                d_q <= '0;
                s_q <= '0;
            end else if (ld[k]) begin
                v_q <= v_in;
                if (v_in) begin
                    d_q <= d_nxt;
                    s_q <= s_in;
                end
            end
        end
    end

    assign bus.in_ready  = ld[0];
    assign bus.out_valid = v[STAGES-1];
    assign bus.out       = stg[STAGES-1].d_q;
    assign bus.out_sel   = stg[STAGES-1].s_q;
endmodule

// File: tb/tb_mux_tree_pipe.sv
// tb/tb_mux_tree_pipe.sv - directed self-checking bench for mux_tree_pipe (SEL_BITS 4, 3 and 1)
module tb_mux_tree_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    mux_tree_pipe_if #(.WIDTH(8), .SEL_BITS(4)) bus4 ();
    mux_tree_pipe_if #(.WIDTH(8), .SEL_BITS(3)) bus3 ();
    mux_tree_pipe_if #(.WIDTH(8), .SEL_BITS(1)) bus1 ();

    mux_tree_pipe #(.WIDTH(8), .SEL_BITS(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));
    mux_tree_pipe #(.WIDTH(8), .SEL_BITS(3)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3));
    mux_tree_pipe #(.WIDTH(8), .SEL_BITS(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic vld, input logic [3:0] s);
        bus4.in_valid = vld;
        bus4.sel      = s;
        #1;
    endtask

    task automatic load_ramp();
        for (int i = 0; i < 16; i++) bus4.a_in[i*8 +: 8] = 8'hA0 + 8'(i);
    endtask

    initial begin
        bus4.in_valid = 1'b0; bus4.sel = '0; bus4.out_ready = 1'b1;
        bus3.in_valid = 1'b0; bus3.sel = '0; bus3.out_ready = 1'b1;
        bus1.in_valid = 1'b0; bus1.sel = '0; bus1.out_ready = 1'b1;
        load_ramp();
        for (int i = 0; i < 8; i++) bus3.a_in[i*8 +: 8] = 8'hA0 + 8'(i);
        bus1.a_in = {8'hA1, 8'hA0};

        // reset state
        step(); step();
        rst = 1'b0;
        #1;
        check("rst_out_valid", 32'(bus4.out_valid), 0);
        check("rst_out", 32'(bus4.out), 0);
        check("rst_out_sel", 32'(bus4.out_sel), 0);
        check("rst_in_ready", 32'(bus4.in_ready), 1);
        step();

        // back-to-back sweep, latency 2
        for (int c = 0; c < 18; c++) begin
            drive(c < 16, 4'(c));
            check("sweep_valid", 32'(bus4.out_valid), 32'(c >= 2));
            if (c >= 2) begin
                check("sweep_out", 32'(bus4.out), 32'h A0 + 32'(c - 2));
                check("sweep_sel", 32'(bus4.out_sel), 32'(c - 2));
            end
            step();
        end

        // backpressure: two words buffer, third waits
        bus4.out_ready = 1'b0;
        drive(1, 4'd3);
        check("bp_rdy0", 32'(bus4.in_ready), 1);
        step();
        drive(1, 4'd7);
        check("bp_rdy1", 32'(bus4.in_ready), 1);
        step();
        drive(1, 4'd12);
        check("bp_full", 32'(bus4.in_ready), 0);
        check("bp_out_a3", 32'(bus4.out), 32'hA3);
        for (int c = 0; c < 3; c++) begin
            step();
            #1;
            check("bp_stall_out", 32'(bus4.out), 32'hA3);
            check("bp_stall_sel", 32'(bus4.out_sel), 3);
            check("bp_stall_rdy", 32'(bus4.in_ready), 0);
        end
        bus4.out_ready = 1'b1;
        #1;
        check("bp_release_rdy", 32'(bus4.in_ready), 1);
        check("bp_release_a3", 32'(bus4.out), 32'hA3);
        step();
        drive(0, 4'd0);
        check("bp_a7", 32'(bus4.out), 32'hA7);
        check("bp_a7_v", 32'(bus4.out_valid), 1);
        step();
        check("bp_ac", 32'(bus4.out), 32'hAC);
        check("bp_ac_v", 32'(bus4.out_valid), 1);
        step();
        check("bp_drain", 32'(bus4.out_valid), 0);

        // bubbles, sel toggled while idle must not leak through
        begin
            logic       iv [5] = '{1, 0, 1, 0, 0};
            logic [3:0] is [5] = '{5, 0, 9, 2, 0};
            logic       ev [5] = '{0, 0, 1, 0, 1};
            logic [7:0] eo [5] = '{8'h00, 8'h00, 8'hA5, 8'hA5, 8'hA9};
            for (int c = 0; c < 5; c++) begin
                drive(iv[c], is[c]);
                check("bub_valid", 32'(bus4.out_valid), 32'(ev[c]));
                if (c >= 2) check("bub_out", 32'(bus4.out), 32'(eo[c]));
                step();
            end
        end
        drive(0, 4'd0);
        step();

        // word indexing at the top of the vector
        bus4.a_in = '0;
        bus4.a_in[15*8 +: 8] = 8'hFF;
        drive(1, 4'd15);
        step();
        drive(1, 4'd14);
        step();
        drive(0, 4'd0);
        check("w15_out", 32'(bus4.out), 32'hFF);
        step();
        check("w14_out", 32'(bus4.out), 32'h00);
        check("w14_sel", 32'(bus4.out_sel), 14);
        step();
        load_ramp();

        // reset with two words in flight
        drive(1, 4'd1);
        step();
        drive(1, 4'd2);
        step();
        drive(0, 4'd0);
        check("mid_pre_valid", 32'(bus4.out_valid), 1);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(bus4.out_valid), 0);
        check("mid_rst_out", 32'(bus4.out), 0);
        step();
        rst = 1'b0;
        #1;
        check("mid_rel_rdy", 32'(bus4.in_ready), 1);
        for (int c = 0; c < 3; c++) begin
            step();
            check("mid_no_stale", 32'(bus4.out_valid), 0);
        end

        // odd select widths
        bus3.in_valid = 1'b1; bus3.sel = 3'd6;
        bus1.in_valid = 1'b1; bus1.sel = 1'b1;
        step();
        bus3.in_valid = 1'b0; bus3.sel = 3'd0;
        bus1.in_valid = 1'b0; bus1.sel = 1'b0;
        #1;
        check("sb1_valid", 32'(bus1.out_valid), 1);
        check("sb1_out", 32'(bus1.out), 32'hA1);
        check("sb3_early", 32'(bus3.out_valid), 0);
        step();
        check("sb3_valid", 32'(bus3.out_valid), 1);
        check("sb3_out", 32'(bus3.out), 32'hA6);
        check("sb3_sel", 32'(bus3.out_sel), 6);
        check("sb1_done", 32'(bus1.out_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
